// File: rtl/ext_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_pkg
// Description : Shared types and helpers for the external bridge bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_bus_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a master index; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_bus_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_rr_select
// Description : Combinational request selector, fixed-priority or round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_bus_rr_select #(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [GW-1:0] i_ptr,
    input  logic          i_rr_mode,
    output logic          o_valid,
    output logic [N-1:0]  o_grant_oh,
    output logic [GW-1:0] o_grant_idx
);

    int w_start;
    int w_idx;

    // Scan from the start index and wrap; fixed mode always starts at 0.
    always_comb begin
        o_valid     = 1'b0;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_idx       = 0;
        w_start     = i_rr_mode ? int'(i_ptr) : 0;
        for (int k = 0; k < N; k++) begin
            w_idx = w_start + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!o_valid && i_req[w_idx]) begin
                o_valid            = 1'b1;
                o_grant_oh[w_idx]  = 1'b1;
                o_grant_idx        = GW'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ext_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_arbiter
// Description : N-to-1 external bridge bus arbiter with acknowledge timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_bus_arbiter
    import ext_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 16,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                                clk_clk,
    input  logic                                reset_reset,
    input  logic [NUM_MASTERS-1:0]              m_bus_enable,
    input  logic [NUM_MASTERS-1:0]              m_rw,
    input  logic [NUM_MASTERS*ADDR_W-1:0]       m_address,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]   m_byte_enable,
    input  logic [NUM_MASTERS*DATA_W-1:0]       m_write_data,
    output logic [DATA_W-1:0]                   m_read_data,
    output logic [NUM_MASTERS-1:0]              m_acknowledge,
    output logic                                m_error,
    output logic [NUM_MASTERS-1:0]              m_irq,
    output logic [ADDR_W-1:0]                   ext_address,
    output logic                                ext_bus_enable,
    output logic [DATA_W/8-1:0]                 ext_byte_enable,
    output logic                                ext_rw,
    output logic [DATA_W-1:0]                   ext_write_data,
    input  logic [DATA_W-1:0]                   ext_read_data,
    input  logic                                ext_acknowledge,
    input  logic                                ext_irq,
    output logic                                busy,
    output logic [grant_w(NUM_MASTERS)-1:0]     grant_id
);

    localparam int c_gw      = grant_w(NUM_MASTERS);
    localparam int c_be_w    = DATA_W / 8;
    localparam int c_cnt_w   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int c_to_last = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_gw-1:0]        r_ptr;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_gw-1:0]        r_grant_id;
    logic [ADDR_W-1:0]      r_ext_address;
    logic                   r_ext_bus_enable;
    logic [c_be_w-1:0]      r_ext_byte_enable;
    logic                   r_ext_rw;
    logic [DATA_W-1:0]      r_ext_write_data;
    logic [DATA_W-1:0]      r_read_data;
    logic [NUM_MASTERS-1:0] r_ack;
    logic                   r_error;

    logic                   w_req_valid;
    logic [NUM_MASTERS-1:0] w_grant_oh;
    logic [c_gw-1:0]        w_grant_idx;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [c_be_w-1:0]      w_sel_be;
    logic                   w_sel_rw;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic                   w_timeout;
    logic [c_gw-1:0]        w_ptr_next;
    logic [NUM_MASTERS-1:0] w_ack_oh;

    ext_bus_rr_select #(
        .N  (NUM_MASTERS),
        .GW (c_gw)
    ) u_select (
        .i_req       (m_bus_enable),
        .i_ptr       (r_ptr),
        .i_rr_mode   (ARB_MODE == ARB_RR),
        .o_valid     (w_req_valid),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx)
    );

    // One-hot AND-OR mux of the winning master's request fields.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_be    = '0;
        w_sel_rw    = 1'b0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_addr  = w_sel_addr  | m_address[i*ADDR_W +: ADDR_W];
                w_sel_be    = w_sel_be    | m_byte_enable[i*c_be_w +: c_be_w];
                w_sel_rw    = w_sel_rw    | m_rw[i];
                w_sel_wdata = w_sel_wdata | m_write_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == c_cnt_w'(c_to_last));
    assign w_ptr_next = (r_grant_id == c_gw'(NUM_MASTERS - 1)) ? '0 : r_grant_id + 1'b1;
    assign w_ack_oh   = NUM_MASTERS'(1) << r_grant_id;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req_valid) w_next_state = BUS;
            BUS:     if (ext_acknowledge || w_timeout) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_ptr             <= '0;
            r_cnt             <= '0;
            r_grant_id        <= '0;
            r_ext_address     <= '0;
            r_ext_bus_enable  <= 1'b0;
            r_ext_byte_enable <= '0;
            r_ext_rw          <= 1'b0;
            r_ext_write_data  <= '0;
            r_read_data       <= '0;
            r_ack             <= '0;
            r_error           <= 1'b0;
        end else begin
            // Acknowledge and error are single-cycle pulses covering DONE only.
            r_ack   <= '0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_valid) begin
                        r_ext_address     <= w_sel_addr;
                        r_ext_byte_enable <= w_sel_be;
                        r_ext_rw          <= w_sel_rw;
                        r_ext_write_data  <= w_sel_wdata;
                        r_ext_bus_enable  <= 1'b1;
                        r_grant_id        <= w_grant_idx;
                    end
                end
                BUS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (ext_acknowledge) begin
                        if (r_ext_rw) begin
                            r_read_data <= ext_read_data;
                        end
                        r_ack            <= w_ack_oh;
                        r_ext_bus_enable <= 1'b0;
                    end else if (w_timeout) begin
                        r_read_data      <= '0;
                        r_error          <= 1'b1;
                        r_ack            <= w_ack_oh;
                        r_ext_bus_enable <= 1'b0;
                    end
                end
                DONE: begin
                    r_ptr <= w_ptr_next;
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign ext_address     = r_ext_address;
    assign ext_bus_enable  = r_ext_bus_enable;
    assign ext_byte_enable = r_ext_byte_enable;
    assign ext_rw          = r_ext_rw;
    assign ext_write_data  = r_ext_write_data;
    assign m_read_data     = r_read_data;
    assign m_acknowledge   = r_ack;
    assign m_error         = r_error;
    assign m_irq           = {NUM_MASTERS{ext_irq}};
    assign busy            = (r_state == BUS) || (r_state == DONE);
    assign grant_id        = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_ext_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_bus_arbiter
// Description : Directed self-checking bench: fixed-priority/timeout instance
//               and round-robin instance driven from shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_bus_arbiter;

    localparam int c_n  = 3;
    localparam int c_aw = 11;
    localparam int c_dw = 16;
    localparam int c_bw = c_dw / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [c_n-1:0]    m_bus_enable;
    logic [c_n-1:0]    m_rw;
    logic [c_n*c_aw-1:0] m_address;
    logic [c_n*c_bw-1:0] m_byte_enable;
    logic [c_n*c_dw-1:0] m_write_data;
    logic [c_dw-1:0]   ext_read_data;
    logic              ext_acknowledge;
    logic              ext_irq;

    logic [c_dw-1:0]   a_rdata,  b_rdata;
    logic [c_n-1:0]    a_ack,    b_ack;
    logic              a_err,    b_err;
    logic [c_n-1:0]    a_irq,    b_irq;
    logic [c_aw-1:0]   a_addr,   b_addr;
    logic              a_ebe,    b_ebe;
    logic [c_bw-1:0]   a_be,     b_be;
    logic              a_rw,     b_rw;
    logic [c_dw-1:0]   a_wdata,  b_wdata;
    logic              a_busy,   b_busy;
    logic [1:0]        a_gid,    b_gid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ext_bus_arbiter #(
        .NUM_MASTERS (c_n), .ADDR_W (c_aw), .DATA_W (c_dw), .ARB_MODE (0), .TIMEOUT (8)
    ) dut_a (
        .clk_clk (clk), .reset_reset (rst),
        .m_bus_enable (m_bus_enable), .m_rw (m_rw), .m_address (m_address),
        .m_byte_enable (m_byte_enable), .m_write_data (m_write_data),
        .m_read_data (a_rdata), .m_acknowledge (a_ack), .m_error (a_err), .m_irq (a_irq),
        .ext_address (a_addr), .ext_bus_enable (a_ebe), .ext_byte_enable (a_be),
        .ext_rw (a_rw), .ext_write_data (a_wdata), .ext_read_data (ext_read_data),
        .ext_acknowledge (ext_acknowledge), .ext_irq (ext_irq),
        .busy (a_busy), .grant_id (a_gid)
    );

    ext_bus_arbiter #(
        .NUM_MASTERS (c_n), .ADDR_W (c_aw), .DATA_W (c_dw), .ARB_MODE (1), .TIMEOUT (0)
    ) dut_b (
        .clk_clk (clk), .reset_reset (rst),
        .m_bus_enable (m_bus_enable), .m_rw (m_rw), .m_address (m_address),
        .m_byte_enable (m_byte_enable), .m_write_data (m_write_data),
        .m_read_data (b_rdata), .m_acknowledge (b_ack), .m_error (b_err), .m_irq (b_irq),
        .ext_address (b_addr), .ext_bus_enable (b_ebe), .ext_byte_enable (b_be),
        .ext_rw (b_rw), .ext_write_data (b_wdata), .ext_read_data (ext_read_data),
        .ext_acknowledge (ext_acknowledge), .ext_irq (ext_irq),
        .busy (b_busy), .grant_id (b_gid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic [c_aw-1:0] a, input logic rw,
                              input logic [c_bw-1:0] be, input logic [c_dw-1:0] wd);
        m_address[i*c_aw +: c_aw]     = a;
        m_rw[i]                       = rw;
        m_byte_enable[i*c_bw +: c_bw] = be;
        m_write_data[i*c_dw +: c_dw]  = wd;
    endtask

    task automatic wait_ack_a(input string tag, output logic found);
        int cyc = 0;
        found = 1'b0;
        while (a_ack == '0 && cyc < 12) begin
            tick();
            cyc++;
        end
        found = (a_ack != '0);
        check(tag, found, 1'b1);
    endtask

    initial begin
        logic       found;
        logic [1:0] rr_exp [4];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0};

        rst = 1'b1;
        m_bus_enable = '0; m_rw = '0; m_address = '0; m_byte_enable = '0;
        m_write_data = '0; ext_read_data = '0; ext_acknowledge = 1'b0; ext_irq = 1'b0;
        tick(); tick();
        check("rst_ebe",   a_ebe,   1'b0);
        check("rst_busy",  a_busy,  1'b0);
        check("rst_gid",   a_gid,   2'd0);
        check("rst_ack",   a_ack,   3'b000);
        check("rst_rdata", a_rdata, 16'h0000);
        check("rst_addr",  a_addr,  11'h000);
        ext_irq = 1'b1;
        #1;
        check("irq_bcast", a_irq, 3'b111);
        ext_irq = 1'b0;
        rst = 1'b0;

        // Single write from master 0, slave acks two cycles after request goes out
        set_master(0, 11'h123, 1'b0, 2'b11, 16'hBEEF);
        m_bus_enable = 3'b001;
        tick();
        check("wr_ebe",   a_ebe,   1'b1);
        check("wr_addr",  a_addr,  11'h123);
        check("wr_wdata", a_wdata, 16'hBEEF);
        check("wr_be",    a_be,    2'b11);
        check("wr_rw",    a_rw,    1'b0);
        check("wr_busy",  a_busy,  1'b1);
        tick();
        check("wr_noack", a_ack, 3'b000);
        ext_acknowledge = 1'b1;
        tick();
        check("wr_ack",     a_ack,  3'b001);
        check("wr_err",     a_err,  1'b0);
        check("wr_ebe_off", a_ebe,  1'b0);
        check("wr_ack_b",   b_ack,  3'b001);
        m_bus_enable = '0; ext_acknowledge = 1'b0;
        tick();
        check("wr_ack_gone", a_ack,  3'b000);
        check("wr_idle",     a_busy, 1'b0);

        // Read from master 1
        set_master(1, 11'h7FF, 1'b1, 2'b11, 16'h0000);
        m_bus_enable = 3'b010;
        tick();
        check("rd_addr", a_addr, 11'h7FF);
        check("rd_rw",   a_rw,   1'b1);
        check("rd_gid",  a_gid,  2'd1);
        ext_acknowledge = 1'b1; ext_read_data = 16'h5A5A;
        tick();
        check("rd_ack",   a_ack,   3'b010);
        check("rd_rdata", a_rdata, 16'h5A5A);
        m_bus_enable = '0; ext_acknowledge = 1'b0; ext_read_data = '0;
        tick();
        check("rd_hold", a_rdata, 16'h5A5A);
        check("rd_ack0", a_ack,   3'b000);

        // Timeout: master 2 read, no acknowledge
        set_master(2, 11'h055, 1'b1, 2'b01, 16'h1234);
        m_bus_enable = 3'b100;
        tick();
        check("to_ebe", a_ebe, 1'b1);
        repeat (7) tick();
        check("to_early", a_ack, 3'b000);
        tick();
        check("to_ack",   a_ack,   3'b100);
        check("to_err",   a_err,   1'b1);
        check("to_rdata", a_rdata, 16'h0000);
        m_bus_enable = '0;
        tick();
        check("to_err_clr", a_err,  1'b0);
        check("to_idle",    a_busy, 1'b0);

        // Acknowledge arriving on the timeout cycle wins
        ext_read_data = 16'h0F0F;
        m_bus_enable = 3'b100;
        tick();
        repeat (7) tick();
        ext_acknowledge = 1'b1;
        tick();
        check("tw_ack",   a_ack,   3'b100);
        check("tw_err",   a_err,   1'b0);
        check("tw_rdata", a_rdata, 16'h0F0F);
        m_bus_enable = '0; ext_acknowledge = 1'b0; ext_read_data = '0;
        tick();

        // Reset while BUS
        set_master(0, 11'h321, 1'b0, 2'b01, 16'hCAFE);
        m_bus_enable = 3'b001;
        tick();
        check("rb_ebe", a_ebe, 1'b1);
        rst = 1'b1;
        tick();
        check("rb_ebe0", a_ebe,  1'b0);
        check("rb_busy", a_busy, 1'b0);
        check("rb_ack",  a_ack,  3'b000);
        rst = 1'b0; m_bus_enable = '0;
        tick();
        check("rb_noack", a_ack, 3'b000);
        m_bus_enable = 3'b001; ext_acknowledge = 1'b1;
        wait_ack_a("rb_new_seen", found);
        check("rb_new_ack", a_ack, 3'b001);
        check("rb_new_err", a_err, 1'b0);
        m_bus_enable = '0; ext_acknowledge = 1'b0;
        tick();

        // Priority vs round robin, all three masters requesting continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_bus_enable = 3'b111; ext_acknowledge = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_ack_a($sformatf("arb_seen%0d", n), found);
            check($sformatf("fix_gid%0d", n), a_gid, 2'd0);
            check($sformatf("fix_ack%0d", n), a_ack, 3'b001);
            check($sformatf("rr_gid%0d",  n), b_gid, rr_exp[n]);
            check($sformatf("rr_ack%0d",  n), b_ack, 3'(1) << rr_exp[n]);
            tick();
        end
        m_bus_enable = '0; ext_acknowledge = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
